// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int COUNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/shift_add_datapath.sv
// Multiplicand/multiplier shift registers and accumulator, one partial product per step.
module shift_add_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_nxt_o
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
    end else if (step_i) begin
      // Operands are at most WIDTH bits each, so the 2*WIDTH sum never carries out.
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, fixed WIDTH-cycle latency, registered outputs.
// Define SIGNED_MODE_EN for two's-complement operands and product.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | one shift/add iteration per cycle, WIDTH iterations
//   DONE  | product new and valid; done/wr_en high for this cycle only
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_en,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               load, step;

`ifdef SIGNED_MODE_EN
  logic neg_q, neg_d;

  // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
  assign op_a   = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign op_b   = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign result = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
`else
  assign op_a   = a;
  assign op_b   = b;
  assign result = acc_nxt;
`endif

  shift_add_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .a_i       (op_a),
    .b_i       (op_b),
    .acc_nxt_o (acc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    load      = 1'b0;
    step      = 1'b0;
`ifdef SIGNED_MODE_EN
    neg_d     = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SIGNED_MODE_EN
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = result;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef SIGNED_MODE_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef SIGNED_MODE_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign wr_en   = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH=16).
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [31:0] product;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_prod = 32'h0;

  shift_add_multiplier #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 16'd3; b = 16'd5;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b done=%b wr_en=%b required 0 0 0", busy, done, wr_en);
    end
    checks++;
    if (product !== 32'h0) begin
      failures++;
      $display("FAIL reset_product: got %h required 00000000", product);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
    last_prod = 32'h0;
  endtask

  task automatic test_multiply();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic [31:0] ve [6];
    va[0] = 16'd3;    vb[0] = 16'd5;    ve[0] = 32'h0000000F;
    va[1] = 16'h0000; vb[1] = 16'h1234; ve[1] = 32'h00000000;
    va[2] = 16'h8000; vb[2] = 16'h8000; ve[2] = 32'h40000000;
    va[3] = 16'd6;    vb[3] = 16'd7;    ve[3] = 32'h0000002A;
`ifdef SIGNED_MODE_EN
    va[4] = 16'hFFFF; vb[4] = 16'hFFFF; ve[4] = 32'h00000001;
    va[5] = 16'hFFFD; vb[5] = 16'd5;    ve[5] = 32'hFFFFFFF1;
`else
    va[4] = 16'hFFFF; vb[4] = 16'hFFFF; ve[4] = 32'hFFFE0001;
    va[5] = 16'hFFFD; vb[5] = 16'd5;    ve[5] = 32'h0004FFF1;
`endif
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; a = va[i]; b = vb[i];
      tick();
      start = 1'b0; a = 16'hA5A5; b = 16'h5A5A;
      for (int j = 0; j < 16; j++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || wr_en !== 1'b0) begin
          failures++;
          $display("FAIL mul%0d_run_c%0d: busy=%b done=%b wr_en=%b required 1 0 0", i, j, busy, done, wr_en);
        end
        checks++;
        if (product !== last_prod) begin
          failures++;
          $display("FAIL mul%0d_hold_c%0d: got %h required %h", i, j, product, last_prod);
        end
        tick();
      end
      checks++;
      if (done !== 1'b1 || wr_en !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL mul%0d_done: busy=%b done=%b wr_en=%b required 1 1 1", i, busy, done, wr_en);
      end
      checks++;
      if (product !== ve[i]) begin
        failures++;
        $display("FAIL mul%0d_product: got %h required %h", i, product, ve[i]);
      end
      last_prod = ve[i];
      tick();
      checks++;
      if (done !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 || product !== last_prod) begin
        failures++;
        $display("FAIL mul%0d_after: busy=%b done=%b wr_en=%b product=%h required 0 0 0 %h",
                 i, busy, done, wr_en, product, last_prod);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int pulses = 0;
    start = 1'b1; a = 16'd3; b = 16'd5;
    tick();
    start = 1'b0;
    for (int j = 0; j < 22; j++) begin
      // A start during RUN (cycle 5) and during DONE (cycle 16) must both be ignored.
      start = (j == 5 || j == 16);
      a = 16'd7; b = 16'd7;
      if (done === 1'b1) pulses++;
      if (j == 17) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL swb_done_start: busy=%b required 0", busy);
        end
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL swb_pulses: got %0d required 1", pulses);
    end
    checks++;
    if (product !== 32'h0000000F) begin
      failures++;
      $display("FAIL swb_product: got %h required 0000000F", product);
    end
    last_prod = 32'h0000000F;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    start = 1'b1; a = 16'd6; b = 16'd7;
    tick();
    start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_state: busy=%b done=%b product=%h required 0 0 00000000", busy, done, product);
    end
    for (int j = 0; j < 20; j++) begin
      if (done === 1'b1 || wr_en === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL rstmid_nodone: got %0d pulses required 0", pulses);
    end
    start = 1'b1; a = 16'd2; b = 16'd4;
    tick();
    start = 1'b0;
    for (int j = 0; j < 16; j++) tick();
    checks++;
    if (done !== 1'b1 || product !== 32'h00000008) begin
      failures++;
      $display("FAIL rstmid_restart: done=%b product=%h required 1 00000008", done, product);
    end
    tick();
    last_prod = 32'h00000008;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    start = 1'b1; a = 16'd100; b = 16'd200;
    tick();
    for (int j = 0; j < 60; j++) begin
      checks++;
      if (done !== ((j == 16) || (j == 34) || (j == 52))) begin
        failures++;
        $display("FAIL b2b_done_c%0d: got %b", j, done);
      end
      if (done === 1'b1) pulses++;
      checks++;
      if (product !== ((j < 16) ? last_prod : 32'h00004E20)) begin
        failures++;
        $display("FAIL b2b_product_c%0d: got %h required %h", j, product,
                 (j < 16) ? last_prod : 32'h00004E20);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL b2b_pulses: got %0d required 3", pulses);
    end
    for (int j = 0; j < 20; j++) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_multiply();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
